// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port async SRAM controller shared by IF (read) and MEM (read/write)
// One access at a time; MEM has priority except directly after its own grant when IF is waiting.
module mem_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              hold,
   output logic [17:0]       ram_addr,
   inout  wire  [DATA_W-1:0] ram_data,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_RECOVER
   } state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(ACCESS_CYCLES - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic [17:0]         r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_mem_rdata;
   logic                r_if_ready;
   logic                r_mem_ready;
   logic                r_last_mem;
   logic                r_sel_mem;

   logic                w_if_cand;
   logic                w_mem_cand;
   logic                w_grant;
   logic                w_grant_mem;
   logic                w_sample;
   logic                w_wr_done;
   logic                w_ce_n;
   logic                w_oe_n;
   logic                w_we_n;
   logic                w_drive;

   // A requester is not eligible in the cycle its ready pulse is showing.
   assign w_if_cand  = if_req & ~r_if_ready;
   assign w_mem_cand = mem_req & ~r_mem_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant     = 1'b0;
      w_grant_mem = 1'b0;
      w_sample    = 1'b0;
      w_wr_done   = 1'b0;
      w_ce_n      = 1'b1;
      w_oe_n      = 1'b1;
      w_we_n      = 1'b1;
      w_drive     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = LP_CNT_LAST;
            if (w_mem_cand && !(r_last_mem && w_if_cand)) begin
               w_grant     = 1'b1;
               w_grant_mem = 1'b1;
               w_state_nxt = mem_we ? S_WR_SETUP : S_READ;
            end else if (w_if_cand) begin
               w_grant     = 1'b1;
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            w_ce_n = 1'b0;
            w_oe_n = 1'b0;
            if (r_cnt == 4'd0) begin
               w_sample    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_WR_SETUP: begin
            w_ce_n      = 1'b0;
            w_drive     = 1'b1;
            w_cnt_nxt   = LP_CNT_LAST;
            w_state_nxt = S_WR_PULSE;
         end
         S_WR_PULSE: begin
            w_ce_n  = 1'b0;
            w_we_n  = 1'b0;
            w_drive = 1'b1;
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_WR_RECOVER;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_WR_RECOVER: begin
            w_ce_n      = 1'b0;
            w_drive     = 1'b1;
            w_wr_done   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= 18'd0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
         r_if_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         r_last_mem  <= 1'b0;
         r_sel_mem   <= 1'b0;
      end else begin
         r_if_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         if (w_grant) begin
            r_addr     <= w_grant_mem ? 18'(mem_addr) : 18'(if_addr);
            r_sel_mem  <= w_grant_mem;
            r_last_mem <= w_grant_mem;
            if (w_grant_mem) begin
               r_wdata <= mem_wdata;
            end
         end
         if (w_sample) begin
            if (r_sel_mem) begin
               r_mem_rdata <= ram_data;
               r_mem_ready <= 1'b1;
            end else begin
               r_if_rdata <= ram_data;
               r_if_ready <= 1'b1;
            end
         end
         if (w_wr_done) begin
            r_mem_ready <= 1'b1;
         end
      end
   end

   assign ram_data  = w_drive ? r_wdata : {DATA_W{1'bz}};
   assign ram_addr  = r_addr;
   assign ram_ce_n  = w_ce_n;
   assign ram_oe_n  = w_oe_n;
   assign ram_we_n  = w_we_n;
   assign if_rdata  = r_if_rdata;
   assign if_ready  = r_if_ready;
   assign mem_rdata = r_mem_rdata;
   assign mem_ready = r_mem_ready;
   assign hold      = w_if_cand | w_mem_cand;

endmodule
